// File: rtl/alu_pkg.sv
// Shared definitions for the execute-stage ALU: operation codes, FSM states
// and default widths.
package alu_pkg;

    localparam int ALU_DATA_W  = 32;
    localparam int ALU_SHAMT_W = 5;

    localparam logic [5:0] F_ADD  = 6'b100000;
    localparam logic [5:0] F_ADDU = 6'b100001;
    localparam logic [5:0] F_SUB  = 6'b100010;
    localparam logic [5:0] F_SUBU = 6'b100011;
    localparam logic [5:0] F_AND  = 6'b100100;
    localparam logic [5:0] F_OR   = 6'b100101;
    localparam logic [5:0] F_XOR  = 6'b100110;
    localparam logic [5:0] F_NOR  = 6'b100111;
    localparam logic [5:0] F_SLT  = 6'b101010;
    localparam logic [5:0] F_SLTU = 6'b101011;
    localparam logic [5:0] F_LUI  = 6'b111100;
    localparam logic [5:0] F_SLLV = 6'b000100;
    localparam logic [5:0] F_SRLV = 6'b000110;
    localparam logic [5:0] F_SRAV = 6'b000111;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

endpackage

// File: rtl/alu_shifter.sv
// Iterative 1-bit-per-cycle shifter for SLLV/SRLV/SRAV. The first step is taken
// on the start edge, so a k-bit shift completes k edges after acceptance.
module alu_shifter
    import alu_pkg::*;
#(
    parameter int DATA_W  = ALU_DATA_W,
    parameter int SHAMT_W = ALU_SHAMT_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [5:0]         func,
    input  logic [SHAMT_W-1:0] shamt,
    input  logic [DATA_W-1:0]  load_val,
    output logic               busy,
    output logic               done,
    output logic [DATA_W-1:0]  result
);

    logic [DATA_W-1:0]  sreg;
    logic [SHAMT_W-1:0] cnt;
    logic               left_q;
    logic               arith_q;

    logic               left;
    logic               arith;
    logic               active;
    logic [DATA_W-1:0]  src;
    logic [SHAMT_W-1:0] cnt_src;
    logic [DATA_W-1:0]  stepped;

    // On the start cycle the step works on the incoming operand directly
    always_comb begin
        left    = start ? (func == F_SLLV) : left_q;
        arith   = start ? (func == F_SRAV) : arith_q;
        src     = start ? load_val : sreg;
        cnt_src = start ? shamt : cnt;
        active  = start || (cnt != '0);
        if (left)
            stepped = {src[DATA_W-2:0], 1'b0};
        else if (arith)
            stepped = {src[DATA_W-1], src[DATA_W-1:1]};
        else
            stepped = {1'b0, src[DATA_W-1:1]};
    end

    assign busy   = (cnt != '0);
    assign done   = active && (cnt_src == SHAMT_W'(1));
    assign result = stepped;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sreg    <= '0;
            cnt     <= '0;
            left_q  <= 1'b0;
            arith_q <= 1'b0;
        end else begin
            if (active) begin
                sreg <= stepped;
                cnt  <= cnt_src - SHAMT_W'(1);
            end
            if (start) begin
                left_q  <= left;
                arith_q <= arith;
            end
        end
    end

endmodule

// File: rtl/alu_exec.sv
// Execute-stage ALU with registered result/zero and an iterative variable shifter.
// Optional signed-overflow flag is built when ALU_OVERFLOW_EN is defined.
module alu_exec
    import alu_pkg::*;
#(
    parameter int DATA_W  = ALU_DATA_W,
    parameter int SHAMT_W = ALU_SHAMT_W
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic [5:0]        i_aluControl,
    input  logic [DATA_W-1:0] i_op1,
    input  logic [DATA_W-1:0] i_op2,
    output logic              o_valid,
    output logic [DATA_W-1:0] o_result,
    output logic              o_zero,
    output logic              o_overflow
);

    state_t state, state_next;

    logic               accept;
    logic               is_shift;
    logic               sh_start;
    logic [SHAMT_W-1:0] shamt;
    logic [DATA_W-1:0]  sum;
    logic [DATA_W-1:0]  diff;
    logic [DATA_W-1:0]  alu_res;
    logic               sh_busy;
    logic               sh_done;
    logic [DATA_W-1:0]  sh_result;

    assign o_ready  = (state == IDLE);
    assign accept   = i_valid && o_ready;
    assign shamt    = i_op1[SHAMT_W-1:0];
    assign is_shift = (i_aluControl == F_SLLV) || (i_aluControl == F_SRLV) ||
                      (i_aluControl == F_SRAV);
    assign sh_start = accept && is_shift && (shamt != '0);
    assign sum      = i_op1 + i_op2;
    assign diff     = i_op1 - i_op2;

    // Shift codes land here only with a zero amount, so they pass op2 through
    always_comb begin
        alu_res = '0;
        case (i_aluControl)
            F_ADD, F_ADDU: alu_res = sum;
            F_SUB, F_SUBU: alu_res = diff;
            F_AND:         alu_res = i_op1 & i_op2;
            F_OR:          alu_res = i_op1 | i_op2;
            F_XOR:         alu_res = i_op1 ^ i_op2;
            F_NOR:         alu_res = ~(i_op1 | i_op2);
            F_SLT:         alu_res = {{(DATA_W-1){1'b0}}, ($signed(i_op1) < $signed(i_op2))};
            F_SLTU:        alu_res = {{(DATA_W-1){1'b0}}, (i_op1 < i_op2)};
            F_LUI:         alu_res = {i_op2[15:0], {(DATA_W-16){1'b0}}};
            F_SLLV, F_SRLV, F_SRAV: alu_res = i_op2;
            default:       alu_res = '0;
        endcase
    end

    alu_shifter #(
        .DATA_W  (DATA_W),
        .SHAMT_W (SHAMT_W)
    ) u_shifter (
        .clk      (i_clk),
        .rst_n    (i_rst_n),
        .start    (sh_start),
        .func     (i_aluControl),
        .shamt    (shamt),
        .load_val (i_op2),
        .busy     (sh_busy),
        .done     (sh_done),
        .result   (sh_result)
    );

    always_ff @(posedge i_clk) begin
        if (!i_rst_n)
            state <= IDLE;
        else
            state <= state_next;
    end

    // SHIFT lingers one cycle past the result so o_ready rises after o_valid
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (sh_start) state_next = SHIFT;
            SHIFT:   if (!sh_busy) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            o_valid  <= 1'b0;
            o_result <= '0;
            o_zero   <= 1'b1;
        end else begin
            o_valid <= 1'b0;
            if (sh_done) begin
                o_valid  <= 1'b1;
                o_result <= sh_result;
                o_zero   <= (sh_result == '0);
            end else if (accept && !sh_start) begin
                o_valid  <= 1'b1;
                o_result <= alu_res;
                o_zero   <= (alu_res == '0);
            end
        end
    end

`ifdef ALU_OVERFLOW_EN
    logic ovf_next;

    // Signed overflow: result sign differs from op1 when the operation could overflow
    always_comb begin
        ovf_next = 1'b0;
        if (i_aluControl == F_ADD)
            ovf_next = (i_op1[DATA_W-1] == i_op2[DATA_W-1]) && (sum[DATA_W-1] != i_op1[DATA_W-1]);
        else if (i_aluControl == F_SUB)
            ovf_next = (i_op1[DATA_W-1] != i_op2[DATA_W-1]) && (diff[DATA_W-1] != i_op1[DATA_W-1]);
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n)
            o_overflow <= 1'b0;
        else if (sh_done)
            o_overflow <= 1'b0;
        else if (accept && !sh_start)
            o_overflow <= ovf_next;
    end
`else
    assign o_overflow = 1'b0;
`endif

endmodule

// File: tb/tb_alu_exec.sv
// Directed self-checking bench for alu_exec; overflow expectations follow
// whether ALU_OVERFLOW_EN is defined for the build.
module tb_alu_exec;

    logic        i_clk;
    logic        i_rst_n;
    logic        i_valid;
    logic        o_ready;
    logic [5:0]  i_aluControl;
    logic [31:0] i_op1;
    logic [31:0] i_op2;
    logic        o_valid;
    logic [31:0] o_result;
    logic        o_zero;
    logic        o_overflow;

    int err_count   = 0;
    int check_count = 0;
    logic exp_ovf_en;

    alu_exec dut (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_valid      (i_valid),
        .o_ready      (o_ready),
        .i_aluControl (i_aluControl),
        .i_op1        (i_op1),
        .i_op2        (i_op2),
        .o_valid      (o_valid),
        .o_result     (o_result),
        .o_zero       (o_zero),
        .o_overflow   (o_overflow)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        check_count++;
        if (got !== exp) begin
            err_count++;
            $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One-cycle request; outputs sampled just after the accepting edge
    task automatic applyStimulus(input logic [5:0] code, input logic [31:0] a, input logic [31:0] b);
        i_valid      = 1'b1;
        i_aluControl = code;
        i_op1        = a;
        i_op2        = b;
        tick();
        i_valid = 1'b0;
    endtask

    logic [5:0]  bb_code [5];
    logic [31:0] bb_a    [5];
    logic [31:0] bb_b    [5];
    logic [31:0] bb_exp  [5];

    initial begin
`ifdef ALU_OVERFLOW_EN
        exp_ovf_en = 1'b1;
`else
        exp_ovf_en = 1'b0;
`endif
        i_rst_n = 1'b0;
        i_valid = 1'b0;
        i_aluControl = 6'b0;
        i_op1 = 32'h0;
        i_op2 = 32'h0;
        tick();
        tick();
        i_rst_n = 1'b1;
        checkOutput("rst_ready", {31'b0, o_ready}, 32'd1);
        checkOutput("rst_valid", {31'b0, o_valid}, 32'd0);
        checkOutput("rst_result", o_result, 32'h0);
        checkOutput("rst_zero", {31'b0, o_zero}, 32'd1);
        checkOutput("rst_ovf", {31'b0, o_overflow}, 32'd0);

        applyStimulus(6'b100000, 32'h7FFF_FFFF, 32'h1);
        checkOutput("add_valid", {31'b0, o_valid}, 32'd1);
        checkOutput("add_result", o_result, 32'h8000_0000);
        checkOutput("add_zero", {31'b0, o_zero}, 32'd0);
        checkOutput("add_ovf", {31'b0, o_overflow}, {31'b0, exp_ovf_en});
        tick();
        checkOutput("add_valid_drop", {31'b0, o_valid}, 32'd0);
        checkOutput("add_result_hold", o_result, 32'h8000_0000);

        applyStimulus(6'b100001, 32'h7FFF_FFFF, 32'h1);
        checkOutput("addu_result", o_result, 32'h8000_0000);
        checkOutput("addu_ovf", {31'b0, o_overflow}, 32'd0);

        applyStimulus(6'b100010, 32'h8000_0000, 32'h1);
        checkOutput("sub_ovf_result", o_result, 32'h7FFF_FFFF);
        checkOutput("sub_ovf", {31'b0, o_overflow}, {31'b0, exp_ovf_en});

        applyStimulus(6'b100010, 32'd5, 32'd5);
        checkOutput("sub_result", o_result, 32'h0);
        checkOutput("sub_zero", {31'b0, o_zero}, 32'd1);
        checkOutput("sub_ovf_clear", {31'b0, o_overflow}, 32'd0);

        applyStimulus(6'b101010, 32'hFFFF_FFFF, 32'h1);
        checkOutput("slt_result", o_result, 32'd1);
        applyStimulus(6'b101011, 32'hFFFF_FFFF, 32'h1);
        checkOutput("sltu_result", o_result, 32'd0);
        checkOutput("sltu_zero", {31'b0, o_zero}, 32'd1);

        // SRAV by 4 with a competing request held through the stall
        i_valid = 1'b1;
        i_aluControl = 6'b000111;
        i_op1 = 32'd4;
        i_op2 = 32'h8000_0000;
        tick();
        i_aluControl = 6'b100000;
        i_op1 = 32'd1;
        i_op2 = 32'd2;
        for (int j = 1; j <= 4; j++) begin
            checkOutput($sformatf("srav_ready_c%0d", j), {31'b0, o_ready}, 32'd0);
            checkOutput($sformatf("srav_valid_c%0d", j), {31'b0, o_valid}, (j == 4) ? 32'd1 : 32'd0);
            if (j == 4)
                checkOutput("srav_result", o_result, 32'hF800_0000);
            tick();
        end
        checkOutput("srav_ready_back", {31'b0, o_ready}, 32'd1);
        checkOutput("srav_held_not_yet", {31'b0, o_valid}, 32'd0);
        tick();
        i_valid = 1'b0;
        checkOutput("held_add_valid", {31'b0, o_valid}, 32'd1);
        checkOutput("held_add_result", o_result, 32'd3);

        applyStimulus(6'b000100, 32'd0, 32'h1234);
        checkOutput("sllv0_valid", {31'b0, o_valid}, 32'd1);
        checkOutput("sllv0_result", o_result, 32'h1234);
        checkOutput("sllv0_ready", {31'b0, o_ready}, 32'd1);

        applyStimulus(6'b111100, 32'h0, 32'hABCD);
        checkOutput("lui_result", o_result, 32'hABCD_0000);

        applyStimulus(6'b000110, 32'd1, 32'h8000_0001);
        checkOutput("srlv1_valid", {31'b0, o_valid}, 32'd1);
        checkOutput("srlv1_ready", {31'b0, o_ready}, 32'd0);
        checkOutput("srlv1_result", o_result, 32'h4000_0000);
        tick();
        checkOutput("srlv1_ready_back", {31'b0, o_ready}, 32'd1);

        // Long shift aborted by reset on its third cycle
        applyStimulus(6'b000100, 32'd31, 32'h1);
        for (int j = 1; j <= 3; j++) begin
            checkOutput($sformatf("abort_valid_c%0d", j), {31'b0, o_valid}, 32'd0);
            if (j < 3)
                tick();
        end
        i_rst_n = 1'b0;
        tick();
        i_rst_n = 1'b1;
        checkOutput("abort_ready", {31'b0, o_ready}, 32'd1);
        checkOutput("abort_valid", {31'b0, o_valid}, 32'd0);
        checkOutput("abort_result", o_result, 32'h0);
        checkOutput("abort_zero", {31'b0, o_zero}, 32'd1);
        checkOutput("abort_ovf", {31'b0, o_overflow}, 32'd0);
        tick();
        checkOutput("abort_no_late_valid", {31'b0, o_valid}, 32'd0);
        applyStimulus(6'b100000, 32'd2, 32'd3);
        checkOutput("post_abort_valid", {31'b0, o_valid}, 32'd1);
        checkOutput("post_abort_result", o_result, 32'd5);

        applyStimulus(6'b111111, 32'h1234_5678, 32'h9ABC_DEF0);
        checkOutput("unknown_result", o_result, 32'h0);
        checkOutput("unknown_zero", {31'b0, o_zero}, 32'd1);
        checkOutput("unknown_ovf", {31'b0, o_overflow}, 32'd0);

        bb_code[0] = 6'b100000; bb_a[0] = 32'd1;        bb_b[0] = 32'd1;        bb_exp[0] = 32'd2;
        bb_code[1] = 6'b100101; bb_a[1] = 32'hF0;       bb_b[1] = 32'h0F;       bb_exp[1] = 32'hFF;
        bb_code[2] = 6'b100110; bb_a[2] = 32'hFF;       bb_b[2] = 32'h0F;       bb_exp[2] = 32'hF0;
        bb_code[3] = 6'b100111; bb_a[3] = 32'h0;        bb_b[3] = 32'h0;        bb_exp[3] = 32'hFFFF_FFFF;
        bb_code[4] = 6'b100100; bb_a[4] = 32'hFF00;     bb_b[4] = 32'h0FF0;     bb_exp[4] = 32'h0F00;
        for (int i = 0; i < 5; i++) begin
            i_valid = 1'b1;
            i_aluControl = bb_code[i];
            i_op1 = bb_a[i];
            i_op2 = bb_b[i];
            tick();
            checkOutput($sformatf("b2b_valid_%0d", i), {31'b0, o_valid}, 32'd1);
            checkOutput($sformatf("b2b_result_%0d", i), o_result, bb_exp[i]);
        end
        i_valid = 1'b0;
        tick();
        checkOutput("b2b_valid_end", {31'b0, o_valid}, 32'd0);

        $display("Result: errors=%0d of %0d checks", err_count, check_count);
        $finish;
    end

endmodule
